// File: rtl/kickstart_multislot_relocator_pkg.sv
// Shared types, address constants and the AutoConfig ROM table for the
// multi-slot Kickstart relocator.
package kickstart_relocator_pkg;

  typedef enum logic [2:0] {
    IDLE,
    DECODE,
    PASS,
    WAIT,
    WRITE,
    ACK
  } busState_t;

  localparam logic [4:0] ROM_HIGH_PREFIX  = 5'b11111;  // $F80000-$FFFFFF
  localparam logic [7:0] LOW_ROM_LIMIT    = 8'h08;     // $000000-$07FFFF
  localparam logic [7:0] CIA_PAGE         = 8'hBF;
  localparam logic [7:0] AC_PAGE          = 8'hE8;
  localparam logic [7:0] AC_BASE_OFFSET   = 8'h48;
  localparam logic [7:0] AC_SHUTUP_OFFSET = 8'h4C;

  // Type/size nibbles are returned as-is; product and manufacturer are inverted.
  function automatic logic [3:0] autoconfig_nibble(
    input logic [7:0]  offset,
    input logic        size512,
    input logic [7:0]  product,
    input logic [15:0] manufacturer
  );
    case (offset)
      8'h00:   return 4'hC;
      8'h02:   return size512 ? 4'h4 : 4'h5;
      8'h04:   return ~product[7:4];
      8'h06:   return ~product[3:0];
      8'h10:   return ~manufacturer[15:12];
      8'h12:   return ~manufacturer[11:8];
      8'h14:   return ~manufacturer[7:4];
      8'h16:   return ~manufacturer[3:0];
      default: return 4'hF;
    endcase
  endfunction

endpackage

// File: rtl/kickstart_multislot_relocator_bus_sync.sv
// Per-bit two-flop synchroniser; each bit resets to its own value so idle
// strobes come out of reset deasserted.
module bus_sync #(
  parameter int WIDTH = 1
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [WIDTH-1:0] resetValue,
  input  logic [WIDTH-1:0] asyncIn,
  output logic [WIDTH-1:0] syncOut
);

  genvar gi;
  for (gi = 0; gi < WIDTH; gi++) begin : g_bit
    logic stage1Reg;
    logic stage2Reg;

    always_ff @(posedge CLK) begin
      if (RESET) begin
        stage1Reg <= resetValue[gi];
        stage2Reg <= resetValue[gi];
      end else begin
        stage1Reg <= asyncIn[gi];
        stage2Reg <= stage1Reg;
      end
    end

    assign syncOut[gi] = stage2Reg;
  end

endmodule

// File: rtl/kickstart_multislot_relocator.sv
// Serves Kickstart from one of several flash slots or the motherboard ROM,
// stepping the mode on each long reset; AutoConfigs flash in motherboard mode.
module kickstart_multislot_relocator
  import kickstart_relocator_pkg::*;
#(
  parameter int          SLOT_BITS       = 2,
  parameter int          WAIT_STATES     = 3,
  parameter int          WR_PULSE        = 4,
  parameter logic [23:0] HOLD_CYCLES     = 24'd7_000_000,
  parameter logic [7:0]  AC_PRODUCT      = 8'h89,
  parameter logic [15:0] AC_MANUFACTURER = 16'h07DB
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic                 CPU_RESET_n,
  input  logic                 CPU_AS_n,
  input  logic                 UDS_n,
  input  logic                 LDS_n,
  input  logic                 RW,
  input  logic [7:0]           ADDRESS_HIGH,
  input  logic [6:0]           ADDRESS_LOW,
  input  logic [3:0]           DATA_IN,
  output logic [3:0]           DATA_OUT,
  output logic                 DATA_OE,
  input  logic                 SIZE_512K,
  output logic                 MB_AS_n,
  output logic                 DTACK_OE,
  output logic [1:0]           FLASH_RD_n,
  output logic [1:0]           FLASH_WR_n,
  output logic [SLOT_BITS-1:0] FLASH_BANK,
  output logic [SLOT_BITS:0]   MODE
);

  localparam int MODE_W = SLOT_BITS + 1;
  localparam logic [MODE_W-1:0] MB_MODE = {1'b1, {SLOT_BITS{1'b0}}};

  logic [3:0] syncBits;
  logic       busResetN, asN, udsN, ldsN;

  bus_sync #(.WIDTH(4)) u_sync (
    .CLK        (CLK),
    .RESET      (RESET),
    .resetValue (4'b1111),
    .asyncIn    ({CPU_RESET_n, CPU_AS_n, UDS_n, LDS_n}),
    .syncOut    (syncBits)
  );

  assign {busResetN, asN, udsN, ldsN} = syncBits;

  busState_t         stateReg, stateNext;
  logic [MODE_W-1:0] modeReg;
  logic [23:0]       holdCntReg;
  logic              overlayReg, configuredReg, baseValidReg;
  logic [3:0]        baseReg, cycleCntReg, nibbleReg;
  logic [1:0]        byteMaskReg;
  logic              flashReadReg, acReadReg;

  logic       flashMode, acHit, baseHit, flashHit;
  logic [1:0] byteMask;
  logic [7:0] acOffset;

  assign flashMode = (modeReg != MB_MODE);
  assign byteMask  = {~udsN, ~ldsN};
  assign acOffset  = {ADDRESS_LOW, 1'b0};
  assign acHit     = !flashMode && !configuredReg && (ADDRESS_HIGH == AC_PAGE);
  assign baseHit   = !flashMode && baseValidReg && (ADDRESS_HIGH[7:4] == baseReg)
                     && (!SIZE_512K || !ADDRESS_HIGH[3]);
  assign flashHit  = flashMode
                     ? ((ADDRESS_HIGH[7:3] == ROM_HIGH_PREFIX) ||
                        ((ADDRESS_HIGH < LOW_ROM_LIMIT) && !overlayReg))
                     : baseHit;

  always_ff @(posedge CLK) begin
    if (RESET) stateReg <= IDLE;
    else       stateReg <= stateNext;
  end

  always_comb begin
    stateNext = stateReg;
    case (stateReg)
      IDLE:   if (!asN) stateNext = DECODE;
      DECODE: begin
        if (asN)                          stateNext = IDLE;
        else if (acHit)                   stateNext = ACK;
        else if (flashHit && RW)          stateNext = WAIT;
        else if (flashHit && !flashMode)  stateNext = WRITE;
        else                              stateNext = PASS;
      end
      WAIT, WRITE: begin
        if (asN)                    stateNext = IDLE;
        else if (cycleCntReg == 4'd1) stateNext = ACK;
      end
      PASS, ACK: if (asN) stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
    if (!busResetN) stateNext = IDLE;
  end

  always_comb begin
    MB_AS_n    = (stateReg != PASS);
    DTACK_OE   = (stateReg == ACK);
    DATA_OE    = (stateReg == ACK) && acReadReg;
    DATA_OUT   = nibbleReg;
    FLASH_RD_n = 2'b11;
    FLASH_WR_n = 2'b11;
    if ((stateReg == WAIT) || ((stateReg == ACK) && flashReadReg)) FLASH_RD_n = ~byteMaskReg;
    if (stateReg == WRITE) FLASH_WR_n = ~byteMaskReg;
    FLASH_BANK = modeReg[SLOT_BITS-1:0];
    MODE       = modeReg;
  end

  // Mode survives bus resets; only the hold counter reaching its limit moves it.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      modeReg       <= '0;
      holdCntReg    <= '0;
      overlayReg    <= 1'b0;
      configuredReg <= 1'b0;
      baseValidReg  <= 1'b0;
      baseReg       <= 4'h0;
      cycleCntReg   <= 4'h0;
      nibbleReg     <= 4'hF;
      byteMaskReg   <= 2'b00;
      flashReadReg  <= 1'b0;
      acReadReg     <= 1'b0;
    end else if (!busResetN) begin
      if (holdCntReg != HOLD_CYCLES) holdCntReg <= holdCntReg + 24'd1;
      if (holdCntReg == HOLD_CYCLES - 24'd1)
        modeReg <= (modeReg == MB_MODE) ? '0 : modeReg + MODE_W'(1);
      overlayReg    <= 1'b0;
      configuredReg <= 1'b0;
      baseValidReg  <= 1'b0;
      baseReg       <= 4'h0;
    end else begin
      holdCntReg <= '0;
      if (stateReg == DECODE && !asN) begin
        byteMaskReg  <= byteMask;
        flashReadReg <= flashHit && RW && !acHit;
        acReadReg    <= acHit && RW;
        nibbleReg    <= autoconfig_nibble(acOffset, SIZE_512K, AC_PRODUCT, AC_MANUFACTURER);
        cycleCntReg  <= RW ? 4'(WAIT_STATES) : 4'(WR_PULSE);
        if (ADDRESS_HIGH == CIA_PAGE && byteMask != 2'b00) overlayReg <= 1'b1;
        if (acHit && !RW) begin
          if (acOffset == AC_BASE_OFFSET) begin
            baseReg       <= DATA_IN;
            baseValidReg  <= 1'b1;
            configuredReg <= 1'b1;
          end else if (acOffset == AC_SHUTUP_OFFSET) begin
            configuredReg <= 1'b1;
          end
        end
      end
      if (stateReg == WAIT || stateReg == WRITE) cycleCntReg <= cycleCntReg - 4'd1;
    end
  end

endmodule

// File: tb/tb_kickstart_multislot_relocator.sv
// Directed bench: flash reads, overlay, long-reset mode stepping, AutoConfig,
// flash writes, early AS negation and reset during a wait.
module tb_kickstart_multislot_relocator;

  localparam logic [23:0] HOLD = 24'd20;

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic       CPU_RESET_n = 1'b1, CPU_AS_n = 1'b1, UDS_n = 1'b1, LDS_n = 1'b1, RW = 1'b1;
  logic [7:0] ADDRESS_HIGH = 8'h00;
  logic [6:0] ADDRESS_LOW = 7'h00;
  logic [3:0] DATA_IN = 4'h0;
  logic       SIZE_512K = 1'b0;
  logic [3:0] DATA_OUT;
  logic       DATA_OE, MB_AS_n, DTACK_OE;
  logic [1:0] FLASH_RD_n, FLASH_WR_n;
  logic [0:0] FLASH_BANK;
  logic [1:0] MODE;

  int compared = 0;
  int mismatched = 0;
  int cyc = 0;

  always #5 CLK = ~CLK;

  kickstart_multislot_relocator #(
    .SLOT_BITS(1), .WAIT_STATES(3), .WR_PULSE(4), .HOLD_CYCLES(HOLD),
    .AC_PRODUCT(8'h89), .AC_MANUFACTURER(16'h07DB)
  ) dut (
    .CLK(CLK), .RESET(RESET), .CPU_RESET_n(CPU_RESET_n), .CPU_AS_n(CPU_AS_n),
    .UDS_n(UDS_n), .LDS_n(LDS_n), .RW(RW), .ADDRESS_HIGH(ADDRESS_HIGH),
    .ADDRESS_LOW(ADDRESS_LOW), .DATA_IN(DATA_IN), .DATA_OUT(DATA_OUT),
    .DATA_OE(DATA_OE), .SIZE_512K(SIZE_512K), .MB_AS_n(MB_AS_n),
    .DTACK_OE(DTACK_OE), .FLASH_RD_n(FLASH_RD_n), .FLASH_WR_n(FLASH_WR_n),
    .FLASH_BANK(FLASH_BANK), .MODE(MODE)
  );

  // Cycle 0 is the state after the first rising edge that samples AS low.
  task automatic start_access(input logic [7:0] ah, input logic [6:0] al, input logic rw,
                              input logic uds, input logic lds, input logic [3:0] din);
    @(negedge CLK);
    ADDRESS_HIGH = ah; ADDRESS_LOW = al; RW = rw; DATA_IN = din;
    UDS_n = uds; LDS_n = lds; CPU_AS_n = 1'b0;
    cyc = -1;
  endtask

  task automatic step_to(input int k);
    while (cyc < k) begin
      @(negedge CLK);
      cyc++;
    end
  endtask

  task automatic end_access();
    CPU_AS_n = 1'b1; UDS_n = 1'b1; LDS_n = 1'b1; RW = 1'b1;
    repeat (4) @(negedge CLK);
  endtask

  task automatic do_hold(input int n);
    @(negedge CLK);
    CPU_RESET_n = 1'b0;
    repeat (n) @(negedge CLK);
    CPU_RESET_n = 1'b1;
    repeat (5) @(negedge CLK);
  endtask

  task automatic test_reset();
    RESET = 1'b1;
    repeat (3) @(negedge CLK);
    compared++; if (MB_AS_n !== 1'b1)     begin mismatched++; $display("FAIL reset_mbas: got %b want 1", MB_AS_n); end
    compared++; if (DTACK_OE !== 1'b0)    begin mismatched++; $display("FAIL reset_dtack: got %b want 0", DTACK_OE); end
    compared++; if (DATA_OE !== 1'b0)     begin mismatched++; $display("FAIL reset_dataoe: got %b want 0", DATA_OE); end
    compared++; if (FLASH_RD_n !== 2'b11) begin mismatched++; $display("FAIL reset_rd: got %b want 11", FLASH_RD_n); end
    compared++; if (FLASH_WR_n !== 2'b11) begin mismatched++; $display("FAIL reset_wr: got %b want 11", FLASH_WR_n); end
    compared++; if (FLASH_BANK !== 1'b0)  begin mismatched++; $display("FAIL reset_bank: got %b want 0", FLASH_BANK); end
    compared++; if (MODE !== 2'd0)        begin mismatched++; $display("FAIL reset_mode: got %0d want 0", MODE); end
    RESET = 1'b0;
    @(negedge CLK);
  endtask

  task automatic test_flash_read();
    start_access(8'hF8, 7'h00, 1'b1, 1'b0, 1'b0, 4'h0);
    for (int k = 0; k <= 7; k++) begin
      step_to(k);
      compared++; if (FLASH_RD_n !== ((k >= 3) ? 2'b00 : 2'b11))
        begin mismatched++; $display("FAIL read_rd_c%0d: got %b want %b", k, FLASH_RD_n, (k >= 3) ? 2'b00 : 2'b11); end
      compared++; if (DTACK_OE !== (k >= 6))
        begin mismatched++; $display("FAIL read_dtack_c%0d: got %b want %b", k, DTACK_OE, k >= 6); end
      compared++; if (MB_AS_n !== 1'b1)
        begin mismatched++; $display("FAIL read_mbas_c%0d: got %b want 1", k, MB_AS_n); end
    end
    compared++; if (FLASH_BANK !== 1'b0) begin mismatched++; $display("FAIL read_bank: got %b want 0", FLASH_BANK); end
    end_access();
    compared++; if (DTACK_OE !== 1'b0 || FLASH_RD_n !== 2'b11)
      begin mismatched++; $display("FAIL read_release: got dtack=%b rd=%b want 0/11", DTACK_OE, FLASH_RD_n); end
  endtask

  task automatic test_overlay();
    start_access(8'h00, 7'h02, 1'b1, 1'b0, 1'b0, 4'h0);
    step_to(3);
    compared++; if (MB_AS_n !== 1'b1 || FLASH_RD_n !== 2'b00)
      begin mismatched++; $display("FAIL ovl_first: got mbas=%b rd=%b want 1/00", MB_AS_n, FLASH_RD_n); end
    step_to(6);
    compared++; if (DTACK_OE !== 1'b1) begin mismatched++; $display("FAIL ovl_first_dtack: got %b want 1", DTACK_OE); end
    end_access();
    start_access(8'hBF, 7'h70, 1'b1, 1'b1, 1'b0, 4'h0);
    step_to(3);
    compared++; if (MB_AS_n !== 1'b0 || DTACK_OE !== 1'b0)
      begin mismatched++; $display("FAIL ovl_cia: got mbas=%b dtack=%b want 0/0", MB_AS_n, DTACK_OE); end
    end_access();
    start_access(8'h00, 7'h02, 1'b1, 1'b0, 1'b0, 4'h0);
    step_to(3);
    compared++; if (MB_AS_n !== 1'b0 || FLASH_RD_n !== 2'b11)
      begin mismatched++; $display("FAIL ovl_second: got mbas=%b rd=%b want 0/11", MB_AS_n, FLASH_RD_n); end
    end_access();
  endtask

  task automatic test_long_reset();
    logic [1:0] expSeq [6];
    int         holdLen [6];
    expSeq  = '{2'd1, 2'd1, 2'd2, 2'd0, 2'd1, 2'd2};
    holdLen = '{int'(HOLD) + 100, int'(HOLD) - 1, int'(HOLD), int'(HOLD) + 100, int'(HOLD) + 100, int'(HOLD) + 100};
    for (int i = 0; i < 6; i++) begin
      do_hold(holdLen[i]);
      compared++; if (MODE !== expSeq[i])
        begin mismatched++; $display("FAIL hold%0d_mode: got %0d want %0d (len %0d)", i, MODE, expSeq[i], holdLen[i]); end
      if (i == 0) begin
        compared++; if (FLASH_BANK !== 1'b1) begin mismatched++; $display("FAIL hold_bank: got %b want 1", FLASH_BANK); end
      end
    end
  endtask

  task automatic test_autoconfig_read();
    logic [6:0] offs [9];
    logic [3:0] exps [9];
    offs = '{7'h00, 7'h01, 7'h02, 7'h03, 7'h04, 7'h08, 7'h09, 7'h0A, 7'h0B};
    exps = '{4'hC, 4'h5, 4'h7, 4'h6, 4'hF, 4'hF, 4'h8, 4'h2, 4'h4};
    for (int i = 0; i < 9; i++) begin
      start_access(8'hE8, offs[i], 1'b1, 1'b0, 1'b0, 4'h0);
      step_to(3);
      compared++; if (DATA_OUT !== exps[i] || DATA_OE !== 1'b1 || DTACK_OE !== 1'b1)
        begin mismatched++; $display("FAIL ac_rd_%02h: got data=%h oe=%b dtack=%b want %h/1/1", {offs[i], 1'b0}, DATA_OUT, DATA_OE, DTACK_OE, exps[i]); end
      end_access();
    end
    SIZE_512K = 1'b1;
    start_access(8'hE8, 7'h01, 1'b1, 1'b0, 1'b0, 4'h0);
    step_to(3);
    compared++; if (DATA_OUT !== 4'h4) begin mismatched++; $display("FAIL ac_size512: got %h want 4", DATA_OUT); end
    end_access();
    SIZE_512K = 1'b0;
  endtask

  task automatic test_autoconfig_write();
    start_access(8'hE8, 7'h24, 1'b0, 1'b0, 1'b0, 4'h2);
    step_to(3);
    compared++; if (DTACK_OE !== 1'b1 || DATA_OE !== 1'b0)
      begin mismatched++; $display("FAIL ac_base_wr: got dtack=%b oe=%b want 1/0", DTACK_OE, DATA_OE); end
    end_access();
    start_access(8'h20, 7'h00, 1'b0, 1'b0, 1'b1, 4'h0);
    for (int k = 2; k <= 7; k++) begin
      step_to(k);
      compared++; if (FLASH_WR_n !== ((k >= 3 && k <= 6) ? 2'b01 : 2'b11))
        begin mismatched++; $display("FAIL wr_c%0d: got %b want %b", k, FLASH_WR_n, (k >= 3 && k <= 6) ? 2'b01 : 2'b11); end
      compared++; if (DTACK_OE !== (k == 7))
        begin mismatched++; $display("FAIL wr_dtack_c%0d: got %b want %b", k, DTACK_OE, k == 7); end
    end
    end_access();
    start_access(8'hE8, 7'h01, 1'b1, 1'b0, 1'b0, 4'h0);
    step_to(3);
    compared++; if (MB_AS_n !== 1'b0) begin mismatched++; $display("FAIL ac_after_cfg: got mbas=%b want 0", MB_AS_n); end
    end_access();
    start_access(8'h28, 7'h00, 1'b1, 1'b0, 1'b0, 4'h0);
    step_to(3);
    compared++; if (FLASH_RD_n !== 2'b00 || MB_AS_n !== 1'b1)
      begin mismatched++; $display("FAIL base_1m_a19: got rd=%b mbas=%b want 00/1", FLASH_RD_n, MB_AS_n); end
    end_access();
    SIZE_512K = 1'b1;
    start_access(8'h28, 7'h00, 1'b1, 1'b0, 1'b0, 4'h0);
    step_to(3);
    compared++; if (FLASH_RD_n !== 2'b11 || MB_AS_n !== 1'b0)
      begin mismatched++; $display("FAIL base_512k_a19: got rd=%b mbas=%b want 11/0", FLASH_RD_n, MB_AS_n); end
    end_access();
    SIZE_512K = 1'b0;
  endtask

  task automatic test_early_negate();
    start_access(8'h20, 7'h00, 1'b1, 1'b0, 1'b0, 4'h0);
    step_to(2);
    CPU_AS_n = 1'b1; UDS_n = 1'b1; LDS_n = 1'b1;
    step_to(4);
    compared++; if (FLASH_RD_n !== 2'b00) begin mismatched++; $display("FAIL early_wait: got %b want 00", FLASH_RD_n); end
    step_to(5);
    compared++; if (FLASH_RD_n !== 2'b11 || DTACK_OE !== 1'b0)
      begin mismatched++; $display("FAIL early_release: got rd=%b dtack=%b want 11/0", FLASH_RD_n, DTACK_OE); end
    step_to(7);
    compared++; if (DTACK_OE !== 1'b0) begin mismatched++; $display("FAIL early_no_dtack: got %b want 0", DTACK_OE); end
    end_access();
  endtask

  task automatic test_reset_during_wait();
    start_access(8'h20, 7'h00, 1'b1, 1'b0, 1'b0, 4'h0);
    step_to(4);
    compared++; if (FLASH_RD_n !== 2'b00) begin mismatched++; $display("FAIL rstw_pre: got %b want 00", FLASH_RD_n); end
    RESET = 1'b1;
    step_to(5);
    compared++; if (FLASH_RD_n !== 2'b11 || FLASH_WR_n !== 2'b11 || DTACK_OE !== 1'b0 || DATA_OE !== 1'b0 || MB_AS_n !== 1'b1)
      begin mismatched++; $display("FAIL rstw_outs: got rd=%b wr=%b dtack=%b oe=%b mbas=%b want 11/11/0/0/1", FLASH_RD_n, FLASH_WR_n, DTACK_OE, DATA_OE, MB_AS_n); end
    compared++; if (MODE !== 2'd0 || FLASH_BANK !== 1'b0)
      begin mismatched++; $display("FAIL rstw_mode: got mode=%0d bank=%b want 0/0", MODE, FLASH_BANK); end
    RESET = 1'b0;
    end_access();
  endtask

  initial begin
    test_reset();
    test_flash_read();
    test_overlay();
    test_long_reset();
    test_autoconfig_read();
    test_autoconfig_write();
    test_early_negate();
    test_reset_during_wait();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
